lgxx_accum_sched: RTL

Sequencer for the Harris `lgxx` update compute unit. It owns the `lgxx` accumulator register and accepts one six-tap padded-input bundle per cycle. For each output pixel it clears the accumulator, applies nine window updates, then presents the result on a valid/ready output stream, walking an `IMG_W`×`IMG_H` frame in raster order. It sits between the padded-input line-buffer stream and the downstream `lxx` consumer.

---
 rtl/harris_sched_pkg.sv | 13 +
 rtl/hcompute_lgxx_stencil_1.sv | 38 +++
 rtl/lgxx_accum_sched.sv | 111 +++++++++++
 3 files changed

// File: rtl/harris_sched_pkg.sv
// Shared types and constants for the Harris lgxx update sequencer and its datapath.
package harris_sched_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StEmit} lgxx_state_t;

  localparam int LGXX_CLAMP_HI = 180;
  localparam int LGXX_CLAMP_LO = -180;
  localparam int LGXX_SHIFT    = 6;
  localparam int COORD_W       = 10;
  localparam int TAP_W         = 16;
  localparam int NUM_TAPS      = 6;

endpackage

// File: rtl/hcompute_lgxx_stencil_1.sv
// lgxx update datapath: weighted tap gradient, clamp, square, shift, accumulate.
module hcompute_lgxx_stencil_1
  import harris_sched_pkg::*;
(
  input  logic [TAP_W-1:0] in0_lgxx_stencil                    [1],
  input  logic [TAP_W-1:0] in1_padded16_global_wrapper_stencil [NUM_TAPS],
  output logic [TAP_W-1:0] out_lgxx_stencil
);

  localparam logic signed [TAP_W-1:0] ClampHi = TAP_W'(LGXX_CLAMP_HI);
  localparam logic signed [TAP_W-1:0] ClampLo = TAP_W'(LGXX_CLAMP_LO);

  logic        [TAP_W-1:0]   g;
  logic signed [TAP_W-1:0]   g_s;
  logic signed [TAP_W-1:0]   g_c;
  logic signed [2*TAP_W-1:0] prod;
  logic        [TAP_W-1:0]   sq;
  logic signed [TAP_W-1:0]   upd;

  always_comb begin
    g = in1_padded16_global_wrapper_stencil[0]
      + in1_padded16_global_wrapper_stencil[1]
      + {in1_padded16_global_wrapper_stencil[2][TAP_W-2:0], 1'b0}
      - in1_padded16_global_wrapper_stencil[3]
      - {in1_padded16_global_wrapper_stencil[4][TAP_W-2:0], 1'b0}
      - in1_padded16_global_wrapper_stencil[5];
    g_s = signed'(g);
    if (g_s > ClampHi)      g_c = ClampHi;
    else if (g_s < ClampLo) g_c = ClampLo;
    else                    g_c = g_s;
    prod = g_c * g_c;
    // |g_c| <= 180, so the square fits in 16 bits without wrapping
    sq  = prod[TAP_W-1:0];
    upd = signed'(sq) >>> LGXX_SHIFT;
    out_lgxx_stencil = in0_lgxx_stencil[0] + unsigned'(upd);
  end

endmodule

// File: rtl/lgxx_accum_sched.sv
// Sequencer owning the lgxx accumulator: nine window updates per pixel, raster frame walk.
module lgxx_accum_sched
  import harris_sched_pkg::*;
#(
  parameter int unsigned IMG_W    = 64,
  parameter int unsigned IMG_H    = 64,
  parameter int unsigned WIN_TAPS = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_TAPS*TAP_W-1:0] in_taps,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAP_W-1:0]          out_data,
  output logic [COORD_W-1:0]        out_x,
  output logic [COORD_W-1:0]        out_y,
  output logic                      out_last
);

  localparam int unsigned KW = (WIN_TAPS > 1) ? $clog2(WIN_TAPS) : 1;
  localparam logic [KW-1:0]      KLast = KW'(WIN_TAPS - 1);
  localparam logic [COORD_W-1:0] XLast = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(IMG_H - 1);

  lgxx_state_t        state_q, state_d;
  logic [TAP_W-1:0]   acc_q;
  logic [TAP_W-1:0]   acc_upd;
  logic [KW-1:0]      k_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic               done_q;
  logic               in_hs, out_hs, at_last;

  logic [TAP_W-1:0] acc_arr  [1];
  logic [TAP_W-1:0] taps_arr [NUM_TAPS];

  always_comb begin
    acc_arr[0] = acc_q;
    for (int i = 0; i < NUM_TAPS; i++) taps_arr[i] = in_taps[i*TAP_W +: TAP_W];
  end

  hcompute_lgxx_stencil_1 u_stencil (
    .in0_lgxx_stencil                    (acc_arr),
    .in1_padded16_global_wrapper_stencil (taps_arr),
    .out_lgxx_stencil                    (acc_upd)
  );

  assign at_last = (x_q == XLast) && (y_q == YLast);
  assign in_hs   = (state_q == StAccum) && in_valid;
  assign out_hs  = (state_q == StEmit) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (in_valid && k_q == KLast) state_d = StEmit;
      StEmit:  if (out_ready) state_d = at_last ? StIdle : StAccum;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StEmit);
    out_last  = (state_q == StEmit) && at_last;
    out_data  = acc_q;
    out_x     = x_q;
    out_y     = y_q;
    done      = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      k_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= out_hs && at_last;
      if (state_q == StIdle && start) begin
        acc_q <= '0;
        k_q   <= '0;
        x_q   <= '0;
        y_q   <= '0;
      end else if (in_hs) begin
        acc_q <= acc_upd;
        k_q   <= (k_q == KLast) ? '0 : k_q + 1'b1;
      end else if (out_hs && !at_last) begin
        acc_q <= '0;
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

endmodule
